// File: rtl/snake_step_sequencer_if.sv
// Signal bundle between game control / renderer and snake_step_sequencer.
// The master drives frame ticks, game mode, keys, grow and segment index;
// the slave (the sequencer) returns head state, segment reads and status.
interface snake_step_sequencer_if #(
  parameter int MAX_LEN = 16
);
  localparam int IW = $clog2(MAX_LEN);

  logic          FRAME_TICK;
  logic          Playing;
  logic          Paused;
  logic          UP;
  logic          DOWN;
  logic          LEFT;
  logic          RIGHT;
  logic          Grow;
  logic [IW-1:0] SegIdx;
  logic [9:0]    HeadX;
  logic [9:0]    HeadY;
  logic [1:0]    Dir;
  logic [IW:0]   Length;
  logic [9:0]    SegX;
  logic [9:0]    SegY;
  logic          SegValid;
  logic          StepStrobe;
  logic          WallHit;

  modport master (
    output FRAME_TICK, Playing, Paused, UP, DOWN, LEFT, RIGHT, Grow, SegIdx,
    input  HeadX, HeadY, Dir, Length, SegX, SegY, SegValid, StepStrobe, WallHit
  );

  modport slave (
    input  FRAME_TICK, Playing, Paused, UP, DOWN, LEFT, RIGHT, Grow, SegIdx,
    output HeadX, HeadY, Dir, Length, SegX, SegY, SegValid, StepStrobe, WallHit
  );
endinterface

// File: rtl/snake_step_sequencer.sv
// Snake motion sequencer: divides frame ticks into movement steps, queues
// turn requests, advances the head with wall detection and keeps a circular
// body-segment buffer with a registered random-access read port.
// Build macro WALL_WRAP_EN: the head wraps around the playfield edges
// instead of halting on a wall hit.
module snake_step_sequencer #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int STEP_PX         = 10,
  parameter int MAX_LEN         = 16,
  parameter int TQ_DEPTH        = 4,
  parameter int X_START         = 60,
  parameter int Y_START         = 60,
  parameter int X_MAX           = 630,
  parameter int Y_MAX           = 470,
  parameter int INIT_LEN        = 2
) (
  input logic                  CLK,
  input logic                  RST,
  snake_step_sequencer_if.slave if_seq
);
  localparam int IW     = $clog2(MAX_LEN);
  localparam int QW     = $clog2(TQ_DEPTH);
  localparam int FCW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int X_WRAP = (X_MAX / STEP_PX) * STEP_PX;
  localparam int Y_WRAP = (Y_MAX / STEP_PX) * STEP_PX;

  typedef enum logic [2:0] {S_WAIT, S_TURN, S_MOVE, S_TRIM, S_HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [FCW-1:0]   r_frame_cnt;
  logic [1:0]       r_dir;
  logic [9:0]       r_head_x, r_head_y;
  logic [IW:0]      r_len;
  logic [IW-1:0]    r_head_ptr;
  logic             r_grow, r_wall_hit;
  logic [9:0]       r_seg_x [MAX_LEN];
  logic [9:0]       r_seg_y [MAX_LEN];
  logic [9:0]       r_rd_x, r_rd_y;
  logic             r_rd_vld;
  logic [1:0]       r_tq [TQ_DEPTH];
  logic [QW-1:0]    r_tq_wr, r_tq_rd;
  logic [QW:0]      r_tq_cnt;
  logic [3:0]       r_key_prev;

  logic [3:0]       w_keys, w_edge;
  logic             w_key_hit, w_enq, w_pop, w_step_due, w_commit, w_oob, w_step_strobe;
  logic [1:0]       w_key_dir, w_ref_dir;
  logic [QW-1:0]    w_tq_last;
  logic [IW-1:0]    w_ptr_dec, w_rd_ptr;
  logic signed [11:0] w_nx, w_ny, w_wx, w_wy;
  logic [9:0]       w_new_x, w_new_y;
  logic             w_unused;

  function automatic logic [9:0] init_seg_x(int k);
    return (k < INIT_LEN) ? 10'(X_START - k * STEP_PX) : 10'd0;
  endfunction

  function automatic logic [9:0] init_seg_y(int k);
    return (k < INIT_LEN) ? 10'(Y_START) : 10'd0;
  endfunction

  assign w_keys    = {if_seq.UP, if_seq.DOWN, if_seq.LEFT, if_seq.RIGHT};
  assign w_edge    = w_keys & ~r_key_prev;
  assign w_tq_last = r_tq_wr - QW'(1);
  assign w_ref_dir = (r_tq_cnt != '0) ? r_tq[w_tq_last] : r_dir;
  // A turn equal or opposite to the reference shares bit 0 of the encoding.
  assign w_enq = if_seq.Playing && !if_seq.Paused && (r_state != S_HALT) && w_key_hit &&
                 (w_key_dir[0] != w_ref_dir[0]) && (r_tq_cnt != (QW+1)'(TQ_DEPTH));
  assign w_pop      = (r_state == S_TURN) && (r_tq_cnt != '0);
  assign w_step_due = (r_state == S_WAIT) && if_seq.FRAME_TICK && !if_seq.Paused &&
                      (r_frame_cnt == FCW'(FRAMES_PER_STEP - 1));
  assign w_ptr_dec  = r_head_ptr - IW'(1);
  assign w_rd_ptr   = r_head_ptr + if_seq.SegIdx;
  assign w_commit   = (r_state == S_MOVE) && !w_oob;

  // Pick the highest-priority new key press: UP > DOWN > LEFT > RIGHT.
  always_comb begin
    w_key_hit = 1'b0;
    w_key_dir = 2'd0;
    if (w_edge[3])      begin w_key_hit = 1'b1; w_key_dir = 2'd3; end
    else if (w_edge[2]) begin w_key_hit = 1'b1; w_key_dir = 2'd1; end
    else if (w_edge[1]) begin w_key_hit = 1'b1; w_key_dir = 2'd2; end
    else if (w_edge[0]) begin w_key_hit = 1'b1; w_key_dir = 2'd0; end
  end

  // Candidate next head, widened so under/overflow is visible to bound checks.
  always_comb begin
    w_nx = {2'b00, r_head_x};
    w_ny = {2'b00, r_head_y};
    case (r_dir)
      2'd0:    w_nx = w_nx + 12'(STEP_PX);
      2'd1:    w_ny = w_ny - 12'(STEP_PX);
      2'd2:    w_nx = w_nx - 12'(STEP_PX);
      default: w_ny = w_ny + 12'(STEP_PX);
    endcase
  end

`ifdef WALL_WRAP_EN
  // Wrap each axis: past the max goes to 0, below 0 goes to the last grid line.
  always_comb begin
    w_wx = w_nx;
    w_wy = w_ny;
    if (w_nx < 0)          w_wx = 12'(X_WRAP);
    else if (w_nx > X_MAX) w_wx = '0;
    if (w_ny < 0)          w_wy = 12'(Y_WRAP);
    else if (w_ny > Y_MAX) w_wy = '0;
  end
  assign w_oob = 1'b0;
`else
  assign w_wx  = w_nx;
  assign w_wy  = w_ny;
  assign w_oob = (w_nx < 0) || (w_nx > X_MAX) || (w_ny < 0) || (w_ny > Y_MAX);
`endif
  assign w_new_x  = w_wx[9:0];
  assign w_new_y  = w_wy[9:0];
  assign w_unused = ^{w_wx[11:10], w_wy[11:10]};

  // FSM state register; Playing low forces WAIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  r_state <= S_WAIT;
    else if (!if_seq.Playing) r_state <= S_WAIT;
    else                      r_state <= w_state_nxt;
  end

  // FSM next state and step strobe.
  always_comb begin
    w_state_nxt   = r_state;
    w_step_strobe = 1'b0;
    case (r_state)
      S_WAIT: if (w_step_due) w_state_nxt = S_TURN;
      S_TURN: w_state_nxt = S_MOVE;
      S_MOVE: w_state_nxt = w_oob ? S_HALT : S_TRIM;
      S_TRIM: begin w_state_nxt = S_WAIT; w_step_strobe = 1'b1; end
      default: w_state_nxt = S_HALT;
    endcase
  end

  // Previous key levels for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_key_prev <= '0;
    else     r_key_prev <= w_keys;
  end

  // Turn-queue storage; contents are only meaningful below the count.
  always_ff @(posedge CLK) begin
    if (w_enq) r_tq[r_tq_wr] <= w_key_dir;
  end

  // Step control: frame divider, queue pointers, direction, head, length.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame_cnt <= '0; r_dir <= 2'd0; r_head_ptr <= '0;
      r_head_x <= 10'(X_START); r_head_y <= 10'(Y_START);
      r_len <= (IW+1)'(INIT_LEN); r_grow <= 1'b0; r_wall_hit <= 1'b0;
      r_tq_wr <= '0; r_tq_rd <= '0; r_tq_cnt <= '0;
    end else if (!if_seq.Playing) begin
      r_frame_cnt <= '0; r_dir <= 2'd0; r_head_ptr <= '0;
      r_head_x <= 10'(X_START); r_head_y <= 10'(Y_START);
      r_len <= (IW+1)'(INIT_LEN); r_grow <= 1'b0; r_wall_hit <= 1'b0;
      r_tq_wr <= '0; r_tq_rd <= '0; r_tq_cnt <= '0;
    end else begin
      if (r_state == S_WAIT && if_seq.FRAME_TICK && !if_seq.Paused)
        r_frame_cnt <= w_step_due ? '0 : r_frame_cnt + FCW'(1);
      if (w_pop) begin
        r_dir   <= r_tq[r_tq_rd];
        r_tq_rd <= r_tq_rd + QW'(1);
      end
      if (w_enq) r_tq_wr <= r_tq_wr + QW'(1);
      if (w_enq && !w_pop)      r_tq_cnt <= r_tq_cnt + (QW+1)'(1);
      else if (!w_enq && w_pop) r_tq_cnt <= r_tq_cnt - (QW+1)'(1);
      if (w_commit) begin
        r_head_x   <= w_new_x;
        r_head_y   <= w_new_y;
        r_head_ptr <= w_ptr_dec;
      end
      if (r_state == S_MOVE && w_oob) r_wall_hit <= 1'b1;
      if (r_state == S_TRIM) begin
        if (r_grow && r_len < (IW+1)'(MAX_LEN)) r_len <= r_len + (IW+1)'(1);
        r_grow <= if_seq.Grow;
      end else if (if_seq.Grow) begin
        r_grow <= 1'b1;
      end
    end
  end

  // Segment ring: new head goes one slot below the old head pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        r_seg_x[k] <= init_seg_x(k);
        r_seg_y[k] <= init_seg_y(k);
      end
    end else if (!if_seq.Playing) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        r_seg_x[k] <= init_seg_x(k);
        r_seg_y[k] <= init_seg_y(k);
      end
    end else if (w_commit) begin
      r_seg_x[w_ptr_dec] <= w_new_x;
      r_seg_y[w_ptr_dec] <= w_new_y;
    end
  end

  // Registered segment read port, relative to the head pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_x <= '0; r_rd_y <= '0; r_rd_vld <= 1'b0;
    end else if (!if_seq.Playing) begin
      r_rd_x <= '0; r_rd_y <= '0; r_rd_vld <= 1'b0;
    end else begin
      r_rd_x   <= r_seg_x[w_rd_ptr];
      r_rd_y   <= r_seg_y[w_rd_ptr];
      r_rd_vld <= ({1'b0, if_seq.SegIdx} < r_len);
    end
  end

  assign if_seq.HeadX      = r_head_x;
  assign if_seq.HeadY      = r_head_y;
  assign if_seq.Dir        = r_dir;
  assign if_seq.Length     = r_len;
  assign if_seq.SegX       = r_rd_x;
  assign if_seq.SegY       = r_rd_y;
  assign if_seq.SegValid   = r_rd_vld;
  assign if_seq.StepStrobe = w_step_strobe;
  assign if_seq.WallHit    = r_wall_hit;
endmodule

// File: tb/tb_snake_step_sequencer.sv
// Directed bench for snake_step_sequencer: reset/init, stepping, turn queue,
// growth and saturation, pause, wall hit (or wrap with WALL_WRAP_EN) and
// asynchronous reset in the middle of a step.
module tb_snake_step_sequencer;
  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   strobe_cnt = 0;
  int   s0;

  snake_step_sequencer_if #(.MAX_LEN(16)) bus ();

  snake_step_sequencer dut (
    .CLK    (CLK),
    .RST    (RST),
    .if_seq (bus)
  );

  always #5 CLK = ~CLK;

  // Count step strobes on the falling edge.
  always @(negedge CLK) if (bus.StepStrobe === 1'b1) strobe_cnt++;

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic tick(input int gap);
    bus.FRAME_TICK = 1'b1; cyc(1);
    bus.FRAME_TICK = 1'b0; cyc(gap);
  endtask

  task automatic do_step();
    for (int i = 0; i < 4; i++) tick((i == 3) ? 5 : 1);
  endtask

  task automatic press(input logic [3:0] k);
    {bus.UP, bus.DOWN, bus.LEFT, bus.RIGHT} = k; cyc(1);
    {bus.UP, bus.DOWN, bus.LEFT, bus.RIGHT} = 4'b0000; cyc(1);
  endtask

  task automatic read_seg(input int idx);
    bus.SegIdx = 4'(idx); cyc(1);
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.Playing = 1'b0; cyc(2);
    n_cmp++; if (bus.HeadX !== 10'd60) begin n_bad++; $display("FAIL rst_headx: got %0d want 60", bus.HeadX); end
    n_cmp++; if (bus.HeadY !== 10'd60) begin n_bad++; $display("FAIL rst_heady: got %0d want 60", bus.HeadY); end
    n_cmp++; if (bus.Dir !== 2'd0) begin n_bad++; $display("FAIL rst_dir: got %0d want 0", bus.Dir); end
    n_cmp++; if (bus.Length !== 5'd2) begin n_bad++; $display("FAIL rst_len: got %0d want 2", bus.Length); end
    n_cmp++; if (bus.WallHit !== 1'b0) begin n_bad++; $display("FAIL rst_wall: got %0d want 0", bus.WallHit); end
    n_cmp++; if (bus.StepStrobe !== 1'b0) begin n_bad++; $display("FAIL rst_strobe: got %0d want 0", bus.StepStrobe); end
    n_cmp++; if ({bus.SegValid, bus.SegX, bus.SegY} !== 21'd0) begin n_bad++; $display("FAIL rst_seg: got %0d/%0d/%0d want 0/0/0", bus.SegValid, bus.SegX, bus.SegY); end
    RST = 1'b0; cyc(2);
    n_cmp++; if (bus.SegValid !== 1'b0) begin n_bad++; $display("FAIL idle_segvalid: got %0d want 0", bus.SegValid); end
  endtask

  task automatic test_first_step();
    bus.Playing = 1'b1; s0 = strobe_cnt;
    do_step();
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL step1_strobes: got %0d want 1", strobe_cnt - s0); end
    n_cmp++; if (bus.HeadX !== 10'd70) begin n_bad++; $display("FAIL step1_headx: got %0d want 70", bus.HeadX); end
    n_cmp++; if (bus.HeadY !== 10'd60) begin n_bad++; $display("FAIL step1_heady: got %0d want 60", bus.HeadY); end
    n_cmp++; if (bus.Length !== 5'd2) begin n_bad++; $display("FAIL step1_len: got %0d want 2", bus.Length); end
    read_seg(1);
    n_cmp++; if ({bus.SegValid, bus.SegX, bus.SegY} !== {1'b1, 10'd60, 10'd60}) begin n_bad++; $display("FAIL step1_seg1: got %0d/%0d/%0d want 1/60/60", bus.SegValid, bus.SegX, bus.SegY); end
    read_seg(0);
    n_cmp++; if ({bus.SegX, bus.SegY} !== {10'd70, 10'd60}) begin n_bad++; $display("FAIL step1_seg0: got %0d/%0d want 70/60", bus.SegX, bus.SegY); end
    read_seg(2);
    n_cmp++; if (bus.SegValid !== 1'b0) begin n_bad++; $display("FAIL step1_seg2_valid: got %0d want 0", bus.SegValid); end
  endtask

  task automatic test_turn_queue();
    press(4'b0001);  // RIGHT while Dir=0, queue empty: dropped
    press(4'b1000);  // UP
    press(4'b0010);  // LEFT
    do_step();
    n_cmp++; if (bus.Dir !== 2'd3) begin n_bad++; $display("FAIL turn1_dir: got %0d want 3", bus.Dir); end
    n_cmp++; if ({bus.HeadX, bus.HeadY} !== {10'd70, 10'd70}) begin n_bad++; $display("FAIL turn1_head: got %0d,%0d want 70,70", bus.HeadX, bus.HeadY); end
    do_step();
    n_cmp++; if (bus.Dir !== 2'd2) begin n_bad++; $display("FAIL turn2_dir: got %0d want 2", bus.Dir); end
    n_cmp++; if ({bus.HeadX, bus.HeadY} !== {10'd60, 10'd70}) begin n_bad++; $display("FAIL turn2_head: got %0d,%0d want 60,70", bus.HeadX, bus.HeadY); end
    do_step();
    n_cmp++; if ({bus.Dir, bus.HeadX} !== {2'd2, 10'd50}) begin n_bad++; $display("FAIL turn3_no_right: got dir %0d x %0d want dir 2 x 50", bus.Dir, bus.HeadX); end
  endtask

  task automatic test_grow();
    press(4'b1000);  // turn up
    bus.Grow = 1'b1; cyc(1); bus.Grow = 1'b0;
    for (int i = 0; i < 3; i++) do_step();
    n_cmp++; if (bus.Length !== 5'd3) begin n_bad++; $display("FAIL grow_len3: got %0d want 3", bus.Length); end
    n_cmp++; if (bus.HeadY !== 10'd100) begin n_bad++; $display("FAIL grow_heady: got %0d want 100", bus.HeadY); end
    read_seg(2);
    n_cmp++; if ({bus.SegValid, bus.SegX, bus.SegY} !== {1'b1, 10'd50, 10'd80}) begin n_bad++; $display("FAIL grow_seg2: got %0d/%0d/%0d want 1/50/80", bus.SegValid, bus.SegX, bus.SegY); end
    read_seg(3);
    n_cmp++; if (bus.SegValid !== 1'b0) begin n_bad++; $display("FAIL grow_seg3_valid: got %0d want 0", bus.SegValid); end
    for (int i = 0; i < 14; i++) begin
      bus.Grow = 1'b1; cyc(1); bus.Grow = 1'b0;
      do_step();
    end
    n_cmp++; if (bus.Length !== 5'd16) begin n_bad++; $display("FAIL grow_sat_len: got %0d want 16", bus.Length); end
    n_cmp++; if (bus.HeadY !== 10'd240) begin n_bad++; $display("FAIL grow_sat_heady: got %0d want 240", bus.HeadY); end
    read_seg(15);
    n_cmp++; if ({bus.SegValid, bus.SegX, bus.SegY} !== {1'b1, 10'd50, 10'd90}) begin n_bad++; $display("FAIL grow_seg15: got %0d/%0d/%0d want 1/50/90", bus.SegValid, bus.SegX, bus.SegY); end
  endtask

  task automatic test_pause();
    tick(1); tick(1);  // frame counter now 2
    bus.Paused = 1'b1; s0 = strobe_cnt;
    for (int i = 0; i < 20; i++) tick(1);
    press(4'b0001);    // ignored while paused
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL pause_strobes: got %0d want 0", strobe_cnt - s0); end
    n_cmp++; if ({bus.HeadX, bus.HeadY} !== {10'd50, 10'd240}) begin n_bad++; $display("FAIL pause_head: got %0d,%0d want 50,240", bus.HeadX, bus.HeadY); end
    bus.Paused = 1'b0;
    tick(5);
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL resume_early: got %0d want 0", strobe_cnt - s0); end
    tick(5);
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL resume_step: got %0d want 1", strobe_cnt - s0); end
    n_cmp++; if ({bus.Dir, bus.HeadY} !== {2'd3, 10'd250}) begin n_bad++; $display("FAIL resume_head: got dir %0d y %0d want dir 3 y 250", bus.Dir, bus.HeadY); end
  endtask

  task automatic test_wall();
    press(4'b0001);  // turn right
    for (int i = 0; i < 58; i++) do_step();
    n_cmp++; if ({bus.HeadX, bus.WallHit} !== {10'd630, 1'b0}) begin n_bad++; $display("FAIL wall_reach: got x %0d hit %0d want 630/0", bus.HeadX, bus.WallHit); end
    s0 = strobe_cnt;
    do_step();
`ifdef WALL_WRAP_EN
    n_cmp++; if ({bus.HeadX, bus.WallHit} !== {10'd0, 1'b0}) begin n_bad++; $display("FAIL wrap_x: got x %0d hit %0d want 0/0", bus.HeadX, bus.WallHit); end
    n_cmp++; if (strobe_cnt - s0 !== 1) begin n_bad++; $display("FAIL wrap_strobe: got %0d want 1", strobe_cnt - s0); end
    do_step();
    n_cmp++; if (bus.HeadX !== 10'd10) begin n_bad++; $display("FAIL wrap_next: got %0d want 10", bus.HeadX); end
`else
    n_cmp++; if ({bus.HeadX, bus.WallHit} !== {10'd630, 1'b1}) begin n_bad++; $display("FAIL wall_hit: got x %0d hit %0d want 630/1", bus.HeadX, bus.WallHit); end
    n_cmp++; if (strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL wall_strobe: got %0d want 0", strobe_cnt - s0); end
    do_step();
    n_cmp++; if ({bus.HeadX, bus.HeadY} !== {10'd630, 10'd250} || strobe_cnt - s0 !== 0) begin n_bad++; $display("FAIL halt_hold: got %0d,%0d strobes %0d want 630,250 strobes 0", bus.HeadX, bus.HeadY, strobe_cnt - s0); end
`endif
    bus.Playing = 1'b0; cyc(1);
    n_cmp++; if ({bus.HeadX, bus.HeadY, bus.Dir, bus.Length, bus.WallHit} !== {10'd60, 10'd60, 2'd0, 5'd2, 1'b0}) begin n_bad++; $display("FAIL replay_init: got %0d,%0d dir %0d len %0d hit %0d want 60,60 dir 0 len 2 hit 0", bus.HeadX, bus.HeadY, bus.Dir, bus.Length, bus.WallHit); end
    bus.Playing = 1'b1; cyc(1);
  endtask

  task automatic test_reset_mid_move();
    press(4'b1000);  // UP
    do_step();
    n_cmp++; if ({bus.HeadX, bus.HeadY} !== {10'd60, 10'd70}) begin n_bad++; $display("FAIL mid_pre: got %0d,%0d want 60,70", bus.HeadX, bus.HeadY); end
    press(4'b0010);  // LEFT
    press(4'b0100);  // DOWN
    for (int i = 0; i < 3; i++) tick(1);
    bus.FRAME_TICK = 1'b1; cyc(1); bus.FRAME_TICK = 1'b0;  // -> TURN
    cyc(1);                                                 // -> MOVE
    RST = 1'b1; #1;
    n_cmp++; if ({bus.HeadX, bus.HeadY, bus.Dir, bus.Length} !== {10'd60, 10'd60, 2'd0, 5'd2}) begin n_bad++; $display("FAIL mid_rst_init: got %0d,%0d dir %0d len %0d want 60,60 dir 0 len 2", bus.HeadX, bus.HeadY, bus.Dir, bus.Length); end
    n_cmp++; if ({bus.StepStrobe, bus.SegValid} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_flags: got strobe %0d valid %0d want 0/0", bus.StepStrobe, bus.SegValid); end
    cyc(1); RST = 1'b0; cyc(1);
    do_step();
    n_cmp++; if ({bus.Dir, bus.HeadX, bus.HeadY} !== {2'd0, 10'd70, 10'd60}) begin n_bad++; $display("FAIL mid_rst_queue: got dir %0d at %0d,%0d want dir 0 at 70,60", bus.Dir, bus.HeadX, bus.HeadY); end
  endtask

  initial begin
    RST = 1'b1;
    bus.FRAME_TICK = 1'b0; bus.Playing = 1'b0; bus.Paused = 1'b0;
    bus.UP = 1'b0; bus.DOWN = 1'b0; bus.LEFT = 1'b0; bus.RIGHT = 1'b0;
    bus.Grow = 1'b0; bus.SegIdx = '0;
    test_reset();
    test_first_step();
    test_turn_queue();
    test_grow();
    test_pause();
    test_wall();
    test_reset_mid_move();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
